// File: rtl/blueintegral_mat_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
// Optional feature macro: MAT_MULT_SAT_EN (saturating output reduction).
package blueintegral_mat_pkg;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;

    // Width used to carry accumulator values through sat_trunc.
    localparam int PW = 128;

    // Full-precision accumulator width: a product plus growth over N terms.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    // Reduce a full-precision sum to out_w bits; values that already fit pass unchanged.
    function automatic logic [PW-1:0] sat_trunc(input logic [PW-1:0] acc, input int out_w);
        logic [PW-1:0] mask;
        mask = (out_w >= PW) ? '1 : ((PW'(1) << out_w) - PW'(1));
`ifdef MAT_MULT_SAT_EN
        return (acc > mask) ? mask : acc;
`else
        return acc & mask;
`endif
    endfunction

endpackage

// File: rtl/blueintegral_mat_mult_seq_if.sv
// Element stream in/out bus for the sequential matrix multiplier.
interface blueintegral_mat_mult_seq_if #(
    parameter int W     = 4,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/blueintegral_mat_mac.sv
// Single multiply-accumulate unit: W x W product into an ACC_W accumulator.
// 'sum' exposes the post-MAC value so the caller can capture it in the same cycle.
module blueintegral_mat_mac #(
    parameter int W     = 4,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] sum
);
    logic [2*W-1:0]   prod;
    logic [ACC_W-1:0] acc;

    assign prod = (2*W)'(a) * (2*W)'(b);
    assign sum  = acc + ACC_W'(prod);

    // Clear has priority so the last term of a dot product and the restart share a cycle.
    always_ff @(posedge clk) begin
        if (clear)   acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/blueintegral_mat_mult_seq.sv
// Sequential NxN matrix multiplier C = A*B: stream A then B in, one MAC per cycle,
// stream C out row-major. Optional MAT_MULT_SAT_EN selects saturating reduction of C.
module blueintegral_mat_mult_seq
    import blueintegral_mat_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 4,
    parameter int OUT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    blueintegral_mat_mult_seq_if.slave  bus,
    output logic                        busy
);
    localparam int ACC_W = acc_width(N, W);
    localparam int NN    = N * N;
    localparam int IW    = $clog2(N);
    localparam int AW    = $clog2(NN);

    localparam logic [1:0] ST_LOAD_A  = 2'(LOAD_A);
    localparam logic [1:0] ST_LOAD_B  = 2'(LOAD_B);
    localparam logic [1:0] ST_COMPUTE = 2'(COMPUTE);
    localparam logic [1:0] ST_DRAIN   = 2'(DRAIN);

    localparam logic [IW-1:0] LAST_K   = IW'(N - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NN - 1);

    logic [1:0]       state;
    logic [AW-1:0]    idx, oidx;
    logic [IW-1:0]    i, j, k;
    logic [W-1:0]     a_mem [NN];
    logic [W-1:0]     b_mem [NN];
    logic [OUT_W-1:0] c_mem [NN];

    logic             in_xfer, out_xfer, last_k, mac_clear, mac_en;
    logic [AW-1:0]    a_addr, b_addr, c_addr;
    logic [ACC_W-1:0] mac_sum;

    assign bus.in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign bus.out_valid = (state == ST_DRAIN);
    assign bus.out_data  = (state == ST_DRAIN) ? c_mem[oidx] : '0;
    assign busy          = (state == ST_COMPUTE) || (state == ST_DRAIN);

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    assign last_k   = (k == LAST_K);

    assign a_addr = AW'(i) * AW'(N) + AW'(k);
    assign b_addr = AW'(k) * AW'(N) + AW'(j);
    assign c_addr = AW'(i) * AW'(N) + AW'(j);

    // Accumulator restarts on reset, on entry to COMPUTE and after each finished dot product.
    assign mac_en    = (state == ST_COMPUTE);
    assign mac_clear = reset
                    || ((state == ST_LOAD_B) && in_xfer && (idx == LAST_IDX))
                    || (mac_en && last_k);

    blueintegral_mat_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (a_mem[a_addr]),
        .b     (b_mem[b_addr]),
        .sum   (mac_sum)
    );

    // Phase sequencing and all index counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD_A;
            idx   <= '0;
            oidx  <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            case (state)
                ST_LOAD_A, ST_LOAD_B: if (in_xfer) begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= (state == ST_LOAD_A) ? ST_LOAD_B : ST_COMPUTE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (!last_k) begin
                        k <= k + IW'(1);
                    end else begin
                        k <= '0;
                        if (j != LAST_K) begin
                            j <= j + IW'(1);
                        end else begin
                            j <= '0;
                            if (i != LAST_K) begin
                                i <= i + IW'(1);
                            end else begin
                                i     <= '0;
                                state <= ST_DRAIN;
                            end
                        end
                    end
                end
                default: if (out_xfer) begin
                    if (oidx == LAST_IDX) begin
                        oidx  <= '0;
                        state <= ST_LOAD_A;
                    end else begin
                        oidx <= oidx + AW'(1);
                    end
                end
            endcase
        end
    end

    // Element storage; contents are don't-care after reset so no clear is needed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (in_xfer && state == ST_LOAD_A) a_mem[idx] <= bus.in_data;
            if (in_xfer && state == ST_LOAD_B) b_mem[idx] <= bus.in_data;
            if (mac_en && last_k)
                c_mem[c_addr] <= OUT_W'(sat_trunc(PW'(mac_sum), OUT_W));
        end
    end
endmodule

// File: tb/tb_blueintegral_mat_mult_seq.sv
// Scoreboard bench for blueintegral_mat_mult_seq (N=2, W=4, OUT_W=8).
// Expected C values are queued when a load starts; a negedge monitor pops on each out transfer.
module tb_blueintegral_mat_mult_seq;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    always #5 clk = ~clk;

    blueintegral_mat_mult_seq_if #(.W(4), .OUT_W(8)) bus ();

    blueintegral_mat_mult_seq #(.N(2), .W(4), .OUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];

`ifdef MAT_MULT_SAT_EN
    localparam int FULL15 = 255;
`else
    localparam int FULL15 = 194;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference 2x2 product; element e of a packed matrix lives at [4e+3:4e].
    function automatic int cref(input logic [15:0] a, input logic [15:0] b, input int e);
        int s, r, c;
        r = e / 2;
        c = e % 2;
        s = 0;
        for (int q = 0; q < 2; q++)
            s += int'(a[(r*2+q)*4 +: 4]) * int'(b[(q*2+c)*4 +: 4]);
`ifdef MAT_MULT_SAT_EN
        return (s > 255) ? 255 : s;
`else
        return s % 256;
`endif
    endfunction

    // Output monitor: every accepted element is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", int'(bus.out_data), -1);
            else                   chk("c_elem", int'(bus.out_data), exp_q.pop_front());
        end
    end

    task automatic send(input logic [3:0] v);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        t = 0;
        while (!bus.in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input bit push);
        if (push) for (int e = 0; e < 4; e++) exp_q.push_back(cref(a, b, e));
        for (int n = 0; n < 4; n++) send(a[n*4 +: 4]);
        for (int n = 0; n < 4; n++) send(b[n*4 +: 4]);
    endtask

    task automatic push4(input int c0, input int c1, input int c2, input int c3);
        exp_q.push_back(c0); exp_q.push_back(c1);
        exp_q.push_back(c2); exp_q.push_back(c3);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // 1: basic product and latency
        push4(19, 22, 43, 50);
        load(16'h4321, 16'h8765, 1'b0);
        bus.in_valid = 1'b0;
        chk("compute_busy", int'(busy), 1);
        chk("compute_in_ready", int'(bus.in_ready), 0);
        wait_valid(n);
        chk("first_out_latency", n, 8);
        wait_done();

        // 2: binary regression, every A pattern paired with a permuted B pattern
        for (int m = 0; m < 16; m++) begin
            logic [3:0] ma, mb;
            logic [15:0] a, b;
            ma = 4'(m);
            mb = 4'((m * 7) % 16);
            a = {3'b0, ma[3], 3'b0, ma[2], 3'b0, ma[1], 3'b0, ma[0]};
            b = {3'b0, mb[3], 3'b0, mb[2], 3'b0, mb[1], 3'b0, mb[0]};
            load(a, b, 1'b1);
            bus.in_valid = 1'b0;
            wait_done();
        end

        // 3: all-15 operands exceed OUT_W (full value 450)
        push4(FULL15, FULL15, FULL15, FULL15);
        load(16'hFFFF, 16'hFFFF, 1'b0);
        bus.in_valid = 1'b0;
        wait_done();

        // 4: output backpressure
        push4(19, 22, 43, 50);
        bus.out_ready = 1'b0;
        load(16'h4321, 16'h8765, 1'b0);
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("stall_latency", n, 8);
        for (int c = 0; c < 5; c++) begin
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_data", int'(bus.out_data), 19);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            bus.out_ready = ~bus.out_ready;
            if (!bus.out_ready) chk("toggle_in_ready", int'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_done();

        // 5: reset in the middle of COMPUTE, then a clean reload
        load(16'h4321, 16'h8765, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        push4(19, 22, 43, 50);
        load(16'h4321, 16'h8765, 1'b0);
        bus.in_valid = 1'b0;
        wait_done();

        // 6: in_valid held high across two runs; junk during COMPUTE must be ignored
        push4(19, 22, 43, 50);
        load(16'h4321, 16'h8765, 1'b0);
        bus.in_data = 4'hF;
        repeat (4) begin @(posedge clk); #1; end
        push4(12, 9, 8, 5);
        load(16'h2103, 16'h1234, 1'b0);
        bus.in_valid = 1'b0;
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
